// File: rtl/periph_timer_unit.sv
// Memory-mapped timer/LED/seven-segment peripheral on the MEM-stage bus.
// Reload timer with sticky interrupt status, free-running SYSTICK and a 4-digit display scanner.
module periph_timer_unit #(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter logic [15:0] SCAN_DIV  = 16'd50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        Mem_rd,
    input  logic        Mem_wr,
    input  logic [31:0] Write_data,
    output logic [31:0] Read_data,
    output logic        irq,
    output logic [7:0]  leds,
    output logic [3:0]  an,
    output logic [7:0]  seg
);

    localparam logic [2:0] OFF_TH      = 3'd0;
    localparam logic [2:0] OFF_TL      = 3'd1;
    localparam logic [2:0] OFF_TCON    = 3'd2;
    localparam logic [2:0] OFF_LED     = 3'd3;
    localparam logic [2:0] OFF_DIGITS  = 3'd4;
    localparam logic [2:0] OFF_SYSTICK = 3'd5;
    localparam logic [15:0] SCAN_LAST  = SCAN_DIV - 16'd1;

    logic [31:0] th, tl, systick;
    logic [2:0]  tcon;
    logic [7:0]  led;
    logic [15:0] digits;
    logic [15:0] scan_cnt;
    logic [1:0]  digit_idx;

    logic       in_window;
    logic [2:0] word;
    logic       wr_th, wr_tl, wr_tcon, wr_led, wr_digits;
    logic       reload;
    logic       unused_byte_lane;

    // Byte lane is irrelevant: every register is a full word.
    assign unused_byte_lane = ^addr[1:0];

    assign in_window = (addr[31:5] == BASE_ADDR[31:5]);
    assign word      = addr[4:2];

    assign wr_th     = Mem_wr && in_window && (word == OFF_TH);
    assign wr_tl     = Mem_wr && in_window && (word == OFF_TL);
    assign wr_tcon   = Mem_wr && in_window && (word == OFF_TCON);
    assign wr_led    = Mem_wr && in_window && (word == OFF_LED);
    assign wr_digits = Mem_wr && in_window && (word == OFF_DIGITS);

    // A CPU write to TL pre-empts the reload, so it cannot raise the status bit either.
    assign reload = tcon[0] && (tl == 32'hFFFF_FFFF) && !wr_tl;

    assign irq  = tcon[1] & tcon[2];
    assign leds = led;

    always_comb begin
        // NOTE: default first so every path assigns Read_data and no latch is inferred.
        Read_data = 32'h0;
        if (Mem_rd && in_window) begin
            case (word)
                OFF_TH:      Read_data = th;
                OFF_TL:      Read_data = tl;
                OFF_TCON:    Read_data = {29'h0, tcon};
                OFF_LED:     Read_data = {24'h0, led};
                OFF_DIGITS:  Read_data = {16'h0, digits};
                OFF_SYSTICK: Read_data = systick;
                default:     Read_data = 32'h0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking so every register samples the pre-edge values (reload uses old TH).
        if (reset) begin
            th      <= 32'h0;
            tl      <= 32'h0;
            tcon    <= 3'h0;
            led     <= 8'h0;
            digits  <= 16'h0;
            systick <= 32'h0;
        end else begin
            systick <= systick + 32'd1;
            if (wr_th)     th     <= Write_data;
            if (wr_led)    led    <= Write_data[7:0];
            if (wr_digits) digits <= Write_data[15:0];

            if (wr_tl)
                tl <= Write_data;
            else if (reload)
                tl <= th;
            else if (tcon[0])
                tl <= tl + 32'd1;

            if (wr_tcon)
                tcon <= Write_data[2:0];
            else if (reload && tcon[1])
                tcon[2] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            scan_cnt  <= 16'h0;
            digit_idx <= 2'd0;
        end else if (scan_cnt >= SCAN_LAST) begin
            scan_cnt  <= 16'h0;
            digit_idx <= digit_idx + 2'd1;
        end else begin
            scan_cnt <= scan_cnt + 16'd1;
        end
    end

    logic [3:0] nibble;
    logic [6:0] hex_abcdefg;

    assign nibble = digits[{digit_idx, 2'b00} +: 4];
    assign an     = ~(4'b0001 << digit_idx);
    assign seg    = {1'b1, ~hex_abcdefg};

    always_comb begin
        hex_abcdefg = 7'h00;
        case (nibble)
            4'h0: hex_abcdefg = 7'h3F;
            4'h1: hex_abcdefg = 7'h06;
            4'h2: hex_abcdefg = 7'h5B;
            4'h3: hex_abcdefg = 7'h4F;
            4'h4: hex_abcdefg = 7'h66;
            4'h5: hex_abcdefg = 7'h6D;
            4'h6: hex_abcdefg = 7'h7D;
            4'h7: hex_abcdefg = 7'h07;
            4'h8: hex_abcdefg = 7'h7F;
            4'h9: hex_abcdefg = 7'h6F;
            4'hA: hex_abcdefg = 7'h77;
            4'hB: hex_abcdefg = 7'h7C;
            4'hC: hex_abcdefg = 7'h39;
            4'hD: hex_abcdefg = 7'h5E;
            4'hE: hex_abcdefg = 7'h79;
            4'hF: hex_abcdefg = 7'h71;
            default: hex_abcdefg = 7'h00;
        endcase
    end

endmodule

// File: tb/tb_periph_timer_unit.sv
// Randomized scoreboard bench for periph_timer_unit against a cycle-level behavioural model.
// The driver pushes expected outputs per cycle; the monitor pops and compares on the falling edge.
module tb_periph_timer_unit;

    localparam logic [31:0] BASE     = 32'h4000_0000;
    localparam int          SCAN_DIV = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic        Mem_rd;
    logic        Mem_wr;
    logic [31:0] Write_data;
    logic [31:0] Read_data;
    logic        irq;
    logic [7:0]  leds;
    logic [3:0]  an;
    logic [7:0]  seg;

    periph_timer_unit #(
        .BASE_ADDR(BASE),
        .SCAN_DIV (16'(SCAN_DIV))
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .addr      (addr),
        .Mem_rd    (Mem_rd),
        .Mem_wr    (Mem_wr),
        .Write_data(Write_data),
        .Read_data (Read_data),
        .irq       (irq),
        .leds      (leds),
        .an        (an),
        .seg       (seg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rd_data;
        logic        irq;
        logic [7:0]  leds;
        logic [3:0]  an;
        logic [7:0]  seg;
    } exp_t;

    exp_t sb_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Behavioural model state: registers plus elapsed cycles since reset.
    logic [31:0] m_th, m_tl, m_systick;
    logic [2:0]  m_tcon;
    logic [7:0]  m_led;
    logic [15:0] m_digits;
    int          m_t;

    logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    function automatic bit in_win(input logic [31:0] a);
        return (a >= BASE) && (a < BASE + 32'h20);
    endfunction

    function automatic int offset_of(input logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    function automatic exp_t model_outputs(input logic rd, input logic [31:0] a);
        exp_t e;
        int idx;
        logic [3:0] nib;
        e.rd_data = 32'h0;
        if (rd && in_win(a)) begin
            case (offset_of(a))
                0: e.rd_data = m_th;
                1: e.rd_data = m_tl;
                2: e.rd_data = 32'(m_tcon);
                3: e.rd_data = 32'(m_led);
                4: e.rd_data = 32'(m_digits);
                5: e.rd_data = m_systick;
                default: e.rd_data = 32'h0;
            endcase
        end
        e.irq  = m_tcon[1] && m_tcon[2];
        e.leds = m_led;
        idx    = (m_t / SCAN_DIV) % 4;
        e.an   = 4'b1111;
        e.an[idx] = 1'b0;
        nib    = 4'((m_digits >> (4 * idx)) & 16'hF);
        e.seg  = {1'b1, ~hex_tab[nib]};
        return e;
    endfunction

    task automatic model_step(input logic r, input logic wr, input logic [31:0] a,
                              input logic [31:0] wd);
        logic [31:0] n_tl;
        logic [2:0]  n_tcon;
        bit          reloaded;
        int          off;
        bit          w;
        if (r) begin
            m_th = 0; m_tl = 0; m_tcon = 0; m_led = 0; m_digits = 0; m_systick = 0; m_t = 0;
            return;
        end
        w   = wr && in_win(a);
        off = offset_of(a);
        reloaded = 0;
        n_tl   = m_tl;
        n_tcon = m_tcon;
        if (w && off == 1) n_tl = wd;
        else if (m_tcon[0]) begin
            if (m_tl == 32'hFFFF_FFFF) begin
                n_tl = m_th;
                reloaded = 1;
            end else n_tl = m_tl + 1;
        end
        if (w && off == 2) n_tcon = wd[2:0];
        else if (reloaded && m_tcon[1]) n_tcon[2] = 1'b1;
        if (w && off == 0) m_th = wd;
        if (w && off == 3) m_led = wd[7:0];
        if (w && off == 4) m_digits = wd[15:0];
        m_tl = n_tl;
        m_tcon = n_tcon;
        m_systick = m_systick + 1;
        m_t = m_t + 1;
    endtask

    // One bus cycle: drive, record expectation, advance model across the edge.
    task automatic apply(input logic r, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] wd);
        reset = r; Mem_rd = rd; Mem_wr = wr; addr = a; Write_data = wd;
        sb_q.push_back(model_outputs(rd, a));
        @(posedge clk);
        model_step(r, wr, a, wd);
        #1;
    endtask

    task automatic wr_reg(input int off, input logic [31:0] wd);
        apply(1'b0, 1'b0, 1'b1, BASE + 32'(off * 4), wd);
    endtask

    task automatic rd_reg(input int off);
        apply(1'b0, 1'b1, 1'b0, BASE + 32'(off * 4), 32'h0);
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        vectors++;
        if (act !== exp_v) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            cmp("read_data", Read_data, e.rd_data);
            cmp("irq", 32'(irq), 32'(e.irq));
            cmp("leds", 32'(leds), 32'(e.leds));
            cmp("an", 32'(an), 32'(e.an));
            cmp("seg", 32'(seg), 32'(e.seg));
        end
    end

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        int pick;
        pick = $urandom_range(0, 15);
        if (pick == 0)      a = BASE - 32'h4;
        else if (pick == 1) a = $urandom;
        else if (pick == 2) a = BASE + 32'h20 + 32'($urandom_range(0, 7) * 4);
        else                a = BASE + 32'($urandom_range(0, 7) * 4);
        return a | 32'($urandom_range(0, 3));
    endfunction

    function automatic logic [31:0] rand_data(input logic [31:0] a);
        if (in_win(a) && offset_of(a) <= 1 && $urandom_range(0, 1) == 1)
            return 32'hFFFF_FFFF - 32'($urandom_range(0, 6));
        if (in_win(a) && offset_of(a) == 2)
            return {$urandom_range(0, 1) == 1 ? 29'h1FFF_FFFF : 29'h0, 3'($urandom_range(0, 7))};
        return $urandom;
    endfunction

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        reset = 1'b1; Mem_rd = 1'b0; Mem_wr = 1'b0; addr = 32'h0; Write_data = 32'h0;
        @(posedge clk);
        model_step(1'b1, 1'b0, 32'h0, 32'h0);
        #1;
        for (int i = 0; i < 6; i++) rd_reg(i);

        // Reload with interrupt, acknowledge, and re-arm.
        wr_reg(0, 32'hFFFF_FFFD);
        wr_reg(1, 32'hFFFF_FFFE);
        wr_reg(2, 32'h3);
        rd_reg(1);
        rd_reg(2);
        rd_reg(1);
        wr_reg(2, 32'h3);
        for (int i = 0; i < 5; i++) rd_reg(2);

        // Enable only: reload without status.
        wr_reg(2, 32'h0);
        wr_reg(1, 32'hFFFF_FFFE);
        wr_reg(2, 32'h1);
        for (int i = 0; i < 4; i++) rd_reg(2);

        // TL write in the reload cycle, then TH write in a reload cycle.
        wr_reg(2, 32'h0);
        wr_reg(1, 32'hFFFF_FFFE);
        wr_reg(2, 32'h3);
        apply(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        wr_reg(1, 32'h5);
        rd_reg(1);
        rd_reg(2);
        wr_reg(1, 32'hFFFF_FFFF);
        wr_reg(0, 32'h1234_5678);
        rd_reg(1);
        rd_reg(2);

        // Display scan of 1A3F, with simultaneous read+write of LED.
        wr_reg(4, 32'h0000_1A3F);
        for (int i = 0; i < 20; i++) rd_reg(4);
        apply(1'b0, 1'b1, 1'b1, BASE + 32'hC, 32'hA5);
        rd_reg(3);

        // Unmapped reads, disabled reads, SYSTICK write ignored, reset over a write.
        rd_reg(6);
        apply(1'b0, 1'b1, 1'b0, 32'h3FFF_FFFC, 32'h0);
        apply(1'b0, 1'b0, 1'b0, BASE + 32'h14, 32'h0);
        wr_reg(5, 32'h0000_0123);
        rd_reg(5);
        apply(1'b1, 1'b1, 1'b1, BASE + 32'h8, 32'h7);
        rd_reg(2);
        rd_reg(5);

        for (int i = 0; i < 2000; i++) begin
            a = rand_addr();
            apply($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 2) == 0, a, rand_data(a));
        end

        apply(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
